// File: rtl/wb_byte_master.sv
// Byte-stream to Wishbone classic master: command byte (+4 write bytes) in, status/read bytes out.
// Optional bus timeout enabled by defining WB_TIMEOUT_EN.
module wb_byte_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [4:0]  adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic        stb_o,
  output logic        cyc_o,
  input  logic        ack_i,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StGetData, StBus, StSend} state_e;

  state_e      state_q, state_d;
  logic [4:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [23:0] resp_q, resp_d;
  // Byte index while collecting write data; bytes still to send after the current one in SEND.
  logic [1:0]  idx_q, idx_d;
  logic        busy_q;

`ifdef WB_TIMEOUT_EN
  logic [7:0]  tmo_q, tmo_d;
`else
  logic [7:0]  unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    resp_d     = resp_q;
    idx_d      = idx_q;
`ifdef WB_TIMEOUT_EN
    tmo_d      = 8'd0;
`endif
    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          idx_d = 2'd0;
          if (rx_data[6:5] != 2'b00) begin
            tx_data_d  = 8'hE1;
            tx_valid_d = 1'b1;
            state_d    = StSend;
          end else begin
            adr_d   = rx_data[4:0];
            we_d    = rx_data[7];
            state_d = rx_data[7] ? StGetData : StBus;
          end
        end
      end
      StGetData: begin
        if (rx_valid) begin
          dat_d[{idx_q, 3'b000} +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StBus;
        end
      end
      StBus: begin
        // Strobe rises one cycle after entry; ack only counts while the strobe is out.
        if (!cyc_q) begin
          cyc_d = 1'b1;
        end else if (ack_i) begin
          cyc_d      = 1'b0;
          tx_valid_d = 1'b1;
          state_d    = StSend;
          if (we_q) begin
            tx_data_d = 8'h00;
            idx_d     = 2'd0;
          end else begin
            tx_data_d = dat_i[7:0];
            resp_d    = dat_i[31:8];
            idx_d     = 2'd3;
          end
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
          cyc_d      = 1'b0;
          tx_data_d  = 8'hEE;
          tx_valid_d = 1'b1;
          idx_d      = 2'd0;
          state_d    = StSend;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      StSend: begin
        if (tx_ready) begin
          if (idx_q == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end else begin
            tx_data_d = resp_q[7:0];
            resp_d    = {8'h00, resp_q[23:8]};
            idx_d     = idx_q - 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      resp_q     <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
`ifdef WB_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      resp_q     <= resp_d;
      idx_q      <= idx_d;
      busy_q     <= (state_d != StIdle);
`ifdef WB_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Held low during reset even though the reset state is IDLE.
  assign rx_ready = rst_n && ((state_q == StIdle) || (state_q == StGetData));
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign adr_o    = adr_q;
  assign dat_o    = dat_q;
  assign we_o     = we_q;
  assign cyc_o    = cyc_q;
  assign stb_o    = cyc_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_wb_byte_master.sv
// Self-checking bench for wb_byte_master: directed commands, a Wishbone slave stub with a small
// coprocessor (reg 0 / reg 4 operands, 12 = AND, 20 = XOR) and a queue-based response model.
module tb_wb_byte_master;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [4:0]  adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic        stb_o;
  logic        cyc_o;
  logic        ack_i;
  logic        busy;

  wb_byte_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .adr_o    (adr_o),
    .dat_o    (dat_o),
    .dat_i    (dat_i),
    .we_o     (we_o),
    .stb_o    (stb_o),
    .cyc_o    (cyc_o),
    .ack_i    (ack_i),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Slave stub
  logic [31:0] sregs [32];
  int          ack_delay = 2;
  bit          no_ack = 0;
  int          wcnt = 0;

  assign dat_i = (adr_o == 5'd12) ? (sregs[0] & sregs[4]) :
                 (adr_o == 5'd20) ? (sregs[0] ^ sregs[4]) : sregs[adr_o];

  always @(posedge clk) begin
    if (cyc_o && stb_o && !ack_i && !no_ack) begin
      if (wcnt >= ack_delay) begin
        ack_i <= 1'b1;
        wcnt  <= 0;
        if (we_o) sregs[adr_o] <= dat_o;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      ack_i <= 1'b0;
      wcnt  <= 0;
    end
  end

  // Response model
  typedef struct packed {
    logic [4:0]  adr;
    logic        we;
    logic [31:0] dat;
  } bus_t;

  logic [31:0] mregs [32];
  logic [7:0]  exp_tx [$];
  bus_t        exp_bus [$];
  logic [7:0]  got_tx [$];
  int          bus_cnt = 0;
  int          last_run = 0;

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd12) return mregs[0] & mregs[4];
    if (a == 5'd20) return mregs[0] ^ mregs[4];
    return mregs[a];
  endfunction

  function automatic logic [31:0] got_word();
    logic [31:0] w = '0;
    for (int i = 0; i < 4 && i < got_tx.size(); i++) w[8*i +: 8] = got_tx[i];
    return w;
  endfunction

  // Per-cycle compare process
  initial begin : compare
    bit          prev_stall = 0;
    bit          prev_ack = 0;
    logic [7:0]  prev_data = '0;
    int          run = 0;
    bus_t        eb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        prev_ack   = 0;
        run        = 0;
      end else begin
        chk("stb_eq_cyc", {31'd0, stb_o}, {31'd0, cyc_o});
        if (prev_ack) chk("cyc_low_after_ack", {31'd0, cyc_o}, 32'd0);
        if (cyc_o || tx_valid) chk("rx_backpressure", {31'd0, rx_ready}, 32'd0);
        if (prev_stall) begin
          chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
          chk("tx_hold_data", {24'd0, tx_data}, {24'd0, prev_data});
        end
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) chk("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
          else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
          got_tx.push_back(tx_data);
        end
        if (cyc_o && stb_o && ack_i) begin
          bus_cnt++;
          if (exp_bus.size() == 0) begin
            chk("bus_unexpected", {27'd0, adr_o}, 32'hFFFF_FFFF);
          end else begin
            eb = exp_bus.pop_front();
            chk("bus_adr", {27'd0, adr_o}, {27'd0, eb.adr});
            chk("bus_we", {31'd0, we_o}, {31'd0, eb.we});
            if (eb.we) chk("bus_dat", dat_o, eb.dat);
          end
        end
        if (stb_o) run++;
        else if (run != 0) begin
          last_run = run;
          run = 0;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_ack   = cyc_o && stb_o && ack_i;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic issue(input logic [7:0] cmd, input logic [31:0] data);
    logic [31:0] r;
    if (cmd[6:5] != 2'b00) begin
      exp_tx.push_back(8'hE1);
    end else begin
      exp_bus.push_back({cmd[4:0], cmd[7], data});
      if (cmd[7]) begin
        mregs[cmd[4:0]] = data;
        exp_tx.push_back(8'h00);
      end else begin
        r = mread(cmd[4:0]);
        for (int i = 0; i < 4; i++) exp_tx.push_back(r[8*i +: 8]);
      end
    end
    send_byte(cmd);
    if (cmd[7] && cmd[6:5] == 2'b00)
      for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while ((exp_tx.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, {31'd0, busy}, 32'd0);
    chk({name, "_tx_left"}, exp_tx.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_high(input string name, input bit use_tx);
    int n = 0;
    while (!(use_tx ? tx_valid : stb_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reached"}, {31'd0, (use_tx ? tx_valid : stb_o)}, 32'd1);
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk({name, "_rst_outs"}, {27'd0, cyc_o, stb_o, tx_valid, busy, rx_ready}, 32'd0);
    repeat (2) @(negedge clk);
    exp_tx.delete();
    exp_bus.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : stimulus
    int b0;
    rst_n    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outs", {rx_ready, tx_valid, adr_o, we_o, stb_o, cyc_o, busy, tx_data, 17'd0},
        32'd0);
    chk("reset_dat", dat_o, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rx_ready", {30'd0, rx_ready, busy}, 32'd2);
    @(posedge clk);
    #1;

    // Write opA
    got_tx.delete();
    issue(8'h80, 32'h1234_5678);
    wait_done("opA");
    chk("opA_dat", dat_o, 32'h1234_5678);
    chk("opA_adr_we", {26'd0, adr_o, we_o}, 32'd1);
    chk("opA_resp", {got_tx.size(), got_tx[0]}, {24'd1, 8'h00});

    // Write opB, read AND
    issue(8'h84, 32'h0F0F_00FF);
    wait_done("opB");
    got_tx.delete();
    issue(8'h0C, 32'd0);
    wait_done("and");
    chk("and_word", got_word(), 32'h0204_0078);
    chk("and_count", got_tx.size(), 32'd4);
    chk("dat_o_retained", dat_o, 32'h0F0F_00FF);

    // Read XOR with stalled consumer
    got_tx.delete();
    tx_ready = 1'b0;
    issue(8'h14, 32'd0);
    wait_high("stall", 1'b1);
    repeat (10) @(negedge clk);
    chk("stall_data", {23'd0, rx_ready, tx_data}, {24'd0, 8'h87});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    wait_done("xor");
    chk("xor_word", got_word(), 32'h1D3B_5687);
    chk("xor_count", got_tx.size(), 32'd4);

    // Reserved bits set
    got_tx.delete();
    b0 = bus_cnt;
    issue(8'h60, 32'd0);
    wait_done("resv");
    chk("resv_resp", {got_tx.size(), got_tx[0]}, {24'd1, 8'hE1});
    chk("resv_no_bus", bus_cnt - b0, 32'd0);
    got_tx.delete();
    issue(8'h00, 32'd0);
    wait_done("after_resv");
    chk("after_resv_word", got_word(), 32'h1234_5678);

`ifdef WB_TIMEOUT_EN
    got_tx.delete();
    no_ack = 1;
    exp_tx.push_back(8'hEE);
    send_byte(8'h02);
    wait_done("tmo");
    chk("tmo_stb_cycles", last_run, 32'd16);
    chk("tmo_resp", {got_tx.size(), got_tx[0]}, {24'd1, 8'hEE});
    no_ack = 0;
`endif

    // Reset mid-BUS
    ack_delay = 30;
    issue(8'h00, 32'd0);
    wait_high("midbus", 1'b0);
    repeat (2) @(posedge clk);
    async_reset("midbus");
    ack_delay = 2;

    // Reset mid-SEND
    tx_ready = 1'b0;
    issue(8'h04, 32'd0);
    wait_high("midsend", 1'b1);
    async_reset("midsend");
    tx_ready = 1'b1;

    // Recovery write/read pair
    issue(8'h85, 32'hCAFE_BABE);
    wait_done("rec_wr");
    got_tx.delete();
    issue(8'h05, 32'd0);
    wait_done("rec_rd");
    chk("rec_word", got_word(), 32'hCAFE_BABE);
    chk("rec_dat_o", dat_o, 32'hCAFE_BABE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
